cpa_pipe_stage: RTL and testbench



---
 rtl/cpa_pipe_stage.sv | 146 ++++++++++++++
 tb/tb_cpa_pipe_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpa_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : cpa_pipe_stage
// Description : Two-stage carry-propagate adder that collapses the two-row
//               output of the 4-column GPC compressor tree into one 10-bit
//               binary sum. Valid/ready handshake on both sides; counts
//               consumed results.
// Revision    : 1.0 - initial release
// ============================================================================
module cpa_pipe_stage #(
   parameter int SPLIT = 5,   // low columns added in stage 1 (1..8)
   parameter int CNT_W = 16   // result counter width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             dst0,
   input  logic [1:0]       dst1,
   input  logic             dst2,
   input  logic [1:0]       dst3,
   input  logic [1:0]       dst4,
   input  logic [1:0]       dst5,
   input  logic [1:0]       dst6,
   input  logic [1:0]       dst7,
   input  logic [1:0]       dst8,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [9:0]       sum,
   output logic [CNT_W-1:0] res_cnt
);

   // Width of the high slice of each row handled in stage 2.
   localparam int HI_W = 9 - SPLIT;

   // Two 9-bit addend rows; columns 0 and 2 have height 1, so row B is 0 there.
   logic [8:0] row_a;
   logic [8:0] row_b;

   assign row_a = {dst8[0], dst7[0], dst6[0], dst5[0], dst4[0], dst3[0],
                   dst2, dst1[0], dst0};
   assign row_b = {dst8[1], dst7[1], dst6[1], dst5[1], dst4[1], dst3[1],
                   1'b0, dst1[1], 1'b0};

   // Stage-1 state
   logic             s1_valid_q, s1_valid_d;
   logic [SPLIT-1:0] s1_lo_q;
   logic             s1_c_q;
   logic [HI_W-1:0]  s1_hia_q;
   logic [HI_W-1:0]  s1_hib_q;

   // Stage-2 state
   logic             s2_valid_q, s2_valid_d;
   logic [SPLIT-1:0] s2_lo_q;
   logic [HI_W:0]    s2_hi_q;

   // Result counter
   logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

   // Handshake qualifiers
   logic s2_free;
   logic advance;
   logic accept;
   logic consume;

   // Adder results
   logic [SPLIT:0] lo_sum;
   logic [HI_W:0]  hi_sum;

   // in_ready depends combinationally on out_ready through s2_free; this
   // lets a full pipeline keep accepting at full rate while draining.
   assign s2_free  = !s2_valid_q || out_ready;
   assign advance  = s1_valid_q && s2_free;
   assign in_ready = !s1_valid_q || s2_free;
   assign accept   = in_valid && in_ready;
   assign consume  = s2_valid_q && out_ready;

   // Low slice sum with carry out in the MSB; high slice absorbs that carry.
   assign lo_sum = {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};
   assign hi_sum = {1'b0, s1_hia_q} + {1'b0, s1_hib_q} + {{HI_W{1'b0}}, s1_c_q};

   // Next-state for the valid bits and the consumed-result counter.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      res_cnt_d  = res_cnt_q;
      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end
      if (advance) begin
         s2_valid_d = 1'b1;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
      if (consume) begin
         res_cnt_d = res_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Control registers: valid bits and counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         res_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         res_cnt_q  <= res_cnt_d;
      end
   end

   // Stage-1 data: loads only when a new beat is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_lo_q  <= '0;
         s1_c_q   <= 1'b0;
         s1_hia_q <= '0;
         s1_hib_q <= '0;
      end else if (accept) begin
         s1_lo_q  <= lo_sum[SPLIT-1:0];
         s1_c_q   <= lo_sum[SPLIT];
         s1_hia_q <= row_a[8:SPLIT];
         s1_hib_q <= row_b[8:SPLIT];
      end
   end

   // Stage-2 data: loads only when stage 1 advances, holds during stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_lo_q <= '0;
         s2_hi_q <= '0;
      end else if (advance) begin
         s2_lo_q <= s1_lo_q;
         s2_hi_q <= hi_sum;
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = {s2_hi_q, s2_lo_q};
   assign res_cnt   = res_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpa_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpa_pipe_stage
// Description : Self-checking bench for cpa_pipe_stage (SPLIT=5/CNT_W=16 and
//               SPLIT=3/CNT_W=4 instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpa_pipe_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] d;

   logic        in_ready, out_valid;
   logic [9:0]  sum;
   logic [15:0] res_cnt;
   logic        in_ready2, out_valid2;
   logic [9:0]  sum2;
   logic [3:0]  res_cnt2;

   // Packed column bus: dst0[0] dst1[2:1] dst2[3] dst3[5:4] ... dst8[15:14]
   logic       dst0, dst2;
   logic [1:0] dst1, dst3, dst4, dst5, dst6, dst7, dst8;
   assign dst0 = d[0];
   assign dst1 = d[2:1];
   assign dst2 = d[3];
   assign dst3 = d[5:4];
   assign dst4 = d[7:6];
   assign dst5 = d[9:8];
   assign dst6 = d[11:10];
   assign dst7 = d[13:12];
   assign dst8 = d[15:14];

   cpa_pipe_stage #(.SPLIT(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3), .dst4(dst4),
      .dst5(dst5), .dst6(dst6), .dst7(dst7), .dst8(dst8),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .res_cnt(res_cnt)
   );

   cpa_pipe_stage #(.SPLIT(3), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3), .dst4(dst4),
      .dst5(dst5), .dst6(dst6), .dst7(dst7), .dst8(dst8),
      .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .res_cnt(res_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: weighted column population count, independent of row split.
   function automatic int ref_sum(input logic [15:0] v);
      int s;
      s = int'(v[0]) + 2 * (int'(v[1]) + int'(v[2])) + 4 * int'(v[3]);
      for (int c = 3; c <= 8; c++)
         s += (int'(v[2*c-2]) + int'(v[2*c-1])) << c;
      return s;
   endfunction

   // Scoreboard: q holds every result in flight, in acceptance order.
   int q[$];
   int exp_cnt = 0;

   // Observe both handshakes on the falling edge; they take effect at the next rise.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_cnt = 0;
         chk("rst_in_ready", in_ready, 1);
      end else begin
         chk("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
         chk("res_cnt", res_cnt, exp_cnt & 32'hFFFF);
         chk("res_cnt_w4", res_cnt2, exp_cnt & 32'hF);
         if (q.size() == 0) chk("idle_out_valid", out_valid, 0);
         if (out_valid && out_ready && q.size() != 0) begin
            int e;
            e = q.pop_front();
            chk("sum", sum, e);
            chk("sum_split3", sum2, e);
            chk("out_valid_split3", out_valid2, 1);
            exp_cnt++;
         end
         if (in_valid && in_ready) q.push_back(ref_sum(d));
      end
   end

   typedef struct packed {
      logic [15:0] d;
      logic [9:0]  exp;
   } vec_t;
   vec_t tbl[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 30 && q.size() != 0; i++) step();
      step();
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'hFFFF, 10'h3F9};  // every bit set: 511 + 506
      tbl[1] = '{16'h00FF, 10'h039};  // carry out of the low 5 columns
      tbl[2] = '{16'h0000, 10'h000};
      tbl[3] = '{16'h0001, 10'h001};
      tbl[4] = '{16'h0003, 10'h003};  // dst1=01, dst0=1
      tbl[5] = '{16'h5500, 10'h1E0};  // rowA bits 5..8 only
      tbl[6] = '{16'hC000, 10'h200};  // dst8=11
      tbl[7] = '{16'h0008, 10'h004};  // dst2 alone
      tbl[8] = '{16'h0004, 10'h002};  // dst1=10
      tbl[9] = '{16'h0030, 10'h010};  // dst3=11

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d = '0;
      repeat (3) step();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_res_cnt", res_cnt, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      // Single beats: two-cycle latency and exact sums.
      for (int i = 0; i < 10; i++) begin
         d = tbl[i].d; in_valid = 1'b1;
         @(negedge clk);
         chk("tbl_in_ready", in_ready, 1);
         step();
         in_valid = 1'b0; d = 16'hA5A5;   // dst may change while idle
         @(negedge clk);
         chk("tbl_lat1_out_valid", out_valid, 0);
         step();
         @(negedge clk);
         chk("tbl_out_valid", out_valid, 1);
         chk("tbl_sum", sum, 32'(tbl[i].exp));
         step();
      end
      chk("single_beat_count", res_cnt, 10);

      // Back-to-back beats 0, 1, 3, 480-pattern: one result per cycle.
      begin
         int bb[4];
         bb = '{2, 3, 4, 5};
         for (int k = 0; k < 6; k++) begin
            if (k < 4) begin d = tbl[bb[k]].d; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (k < 4) chk("b2b_in_ready", in_ready, 1);
            if (k >= 2) begin
               chk("b2b_out_valid", out_valid, 1);
               chk("b2b_sum", sum, 32'(tbl[bb[k-2]].exp));
            end
            step();
         end
         drain();
      end

      // Stall with two beats in flight and a third waiting.
      out_ready = 1'b0;
      d = tbl[0].d; in_valid = 1'b1;
      step();
      d = tbl[1].d;
      @(negedge clk);
      chk("stall_in_ready_2nd", in_ready, 1);
      step();
      d = tbl[5].d;
      @(negedge clk);
      chk("stall_in_ready_low", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_sum", sum, 32'h3F9);
         chk("stall_in_ready", in_ready, 0);
      end
      step();
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      drain();

      // Asynchronous reset mid-stall with two results in flight.
      out_ready = 1'b0;
      d = tbl[0].d; in_valid = 1'b1;
      step();
      d = tbl[6].d;
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_sum", sum, 0);
      chk("arst_res_cnt", res_cnt, 0);
      chk("arst_res_cnt_w4", res_cnt2, 0);
      chk("arst_in_ready", in_ready, 1);
      step();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      d = tbl[1].d; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 1);
      chk("post_rst_sum", sum, 32'h039);
      step();

      // 16 more results: 17 since reset wraps the 4-bit counter to 1.
      for (int i = 0; i < 16; i++) begin
         d = 16'($urandom); in_valid = 1'b1;
         step();
      end
      drain();
      chk("wrap_res_cnt_w4", res_cnt2, 1);
      chk("wrap_res_cnt", res_cnt, 17);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         d = 16'($urandom);
         in_valid = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
